button_conditioner: RTL and testbench



---
 rtl/button_conditioner_pkg.sv | 22 ++
 rtl/button_channel.sv | 119 +++++++++++
 rtl/button_conditioner.sv | 38 +++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared FSM state encodings, 10 MHz timing defaults and a counter-range helper.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package button_conditioner_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMING = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;
    localparam logic [1:0] ST_REPEAT = 2'd3;

    localparam int CLK_HZ              = 10_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 512;
    localparam int DEF_HOLD_CYCLES     = CLK_HZ / 2;   // 0.5 s
    localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 5;   // 0.2 s
    localparam int DEF_CNT_W           = 24;

    // True when a cycle count is at least 1 and does not exceed 2**width.
    function automatic bit fits_cnt(input longint value, input int width);
        return (value >= 64'sd1) && (value <= (64'sd1 <<< width));
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-FF synchronizer, debounce/hold/repeat counter and FSM.
// Latency: press pulse DEBOUNCE_CYCLES+2 edges after raw is first sampled high.
// Backpressure: none; pulses are one-cycle strobes the consumer must take.
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_pulse,
    output logic btn_level
);

    // Refuse to elaborate when a timing value cannot be counted in CNT_W bits.
    if (!fits_cnt(longint'(DEBOUNCE_CYCLES), CNT_W) ||
        !fits_cnt(longint'(HOLD_CYCLES), CNT_W) ||
        !fits_cnt(longint'(REPEAT_CYCLES), CNT_W)) begin : g_param_err
        $error("button_channel: timing parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // Debounce, hold and repeat sequencing; any low s2 sample releases at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            btn_pulse <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            btn_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt       <= '0;
                    btn_level <= 1'b0;
                    if (s2) begin
                        state <= ST_ARMING;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_ARMING: begin
                    if (!s2) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= ST_HELD;
                        cnt       <= '0;
                        btn_pulse <= 1'b1;
                        btn_level <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!s2) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else if (cnt == HOLD_LAST) begin
                        // Saturate here until repeat is enabled.
                        if (repeat_en) begin
                            state     <= ST_REPEAT;
                            cnt       <= '0;
                            btn_pulse <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!s2) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else if (!repeat_en) begin
                        state <= ST_HELD;
                        cnt   <= HOLD_LAST;
                    end else if (cnt == REP_LAST) begin
                        cnt       <= '0;
                        btn_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// NUM_BTN independent debounced buttons with press pulse and optional auto-repeat.
// Latency: press pulse DEBOUNCE_CYCLES+2 edges after raw is first sampled high.
// Backpressure: none; simultaneous pulses are left for the consumer to prioritise.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level
);

    // One self-contained channel per button.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn_raw   (btn_raw[i]),
            .repeat_en (repeat_en[i]),
            .btn_pulse (btn_pulse[i]),
            .btn_level (btn_level[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed stimulus checked each cycle against a run-length model.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_conditioner;

    localparam int NB   = 4;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] repeat_en;
    logic [NB-1:0] btn_pulse;
    logic [NB-1:0] btn_level;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP),
        .CNT_W           (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .btn_pulse (btn_pulse),
        .btn_level (btn_level)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: raw goes through a 2-deep delay; h counts consecutive high
    // synchronized samples. Press at h==DB, repeats at DB+HOLD+k*REP.
    logic          m_s1 [NB];
    logic          m_s2 [NB];
    int            h    [NB];
    logic [NB-1:0] e_pulse;
    logic [NB-1:0] e_level;
    int            pcnt [NB];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NB; i++) begin
            if (reset) begin
                m_s1[i]    = 1'b0;
                m_s2[i]    = 1'b0;
                h[i]       = 0;
                e_pulse[i] = 1'b0;
                e_level[i] = 1'b0;
            end else begin
                h[i]       = m_s2[i] ? h[i] + 1 : 0;
                e_pulse[i] = (h[i] == DB) ||
                             (repeat_en[i] && h[i] >= DB + HOLD &&
                              ((h[i] - DB - HOLD) % REP) == 0);
                e_level[i] = (h[i] >= DB);
                m_s2[i]    = m_s1[i];
                m_s1[i]    = btn_raw[i];
            end
        end
    endtask

    // One clock: update model at the edge, compare 1 time unit later.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, " pulse"}, 32'(btn_pulse), 32'(e_pulse));
        chk({tag, " level"}, 32'(btn_level), 32'(e_level));
        for (int i = 0; i < NB; i++) if (btn_pulse[i]) pcnt[i]++;
        @(negedge clk);
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < NB; i++) pcnt[i] = 0;
    endtask

    task automatic idle(input int n);
        btn_raw = '0;
        for (int k = 0; k < n; k++) cyc("idle");
    endtask

    int            first;
    logic [NB-1:0] simul;
    logic [NB-1:0] bounce_pat;

    initial begin
        reset     = 1'b1;
        btn_raw   = '0;
        repeat_en = '0;
        for (int i = 0; i < NB; i++) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; h[i] = 0; pcnt[i] = 0;
        end
        e_pulse = '0;
        e_level = '0;
        cyc("reset");
        cyc("reset");
        reset = 1'b0;
        idle(3);

        // Clean press on channel 0.
        clr_cnt();
        first = -1;
        for (int k = 0; k < 8; k++) begin
            btn_raw[0] = 1'b1;
            cyc("t1");
            if (btn_pulse[0] && first < 0) first = k + 1;
        end
        idle(5);
        chk("t1 latency edges", 32'(first), 32'd6);
        chk("t1 pulse count", 32'(pcnt[0]), 32'd1);

        // Bounce on channel 1: 1,1,1,0 then held.
        clr_cnt();
        bounce_pat = 4'b1110;
        for (int k = 0; k < 12; k++) begin
            btn_raw[1] = (k < 4) ? bounce_pat[3-k] : 1'b1;
            cyc("t2");
        end
        idle(5);
        chk("t2 pulse count", 32'(pcnt[1]), 32'd1);

        // Auto-repeat on channel 2, held 30 cycles.
        repeat_en[2] = 1'b1;
        clr_cnt();
        for (int k = 0; k < 30; k++) begin
            btn_raw[2] = 1'b1;
            cyc("t3");
        end
        idle(6);
        chk("t3 pulse count", 32'(pcnt[2]), 32'd7);

        // Repeat disabled on channel 3, held 30 cycles.
        clr_cnt();
        for (int k = 0; k < 30; k++) begin
            btn_raw[3] = 1'b1;
            cyc("t4");
        end
        chk("t4 level held", 32'(btn_level[3]), 32'd1);
        idle(6);
        chk("t4 pulse count", 32'(pcnt[3]), 32'd1);

        // Simultaneous press on channels 0 and 2.
        simul = '0;
        for (int k = 0; k < 8; k++) begin
            btn_raw = 4'b0101;
            cyc("t5");
            if (btn_pulse != '0 && simul == '0) simul = btn_pulse;
        end
        idle(5);
        chk("t5 simultaneous", 32'(simul), 32'h5);

        // Repeat enable dropped while repeating stops further pulses.
        for (int k = 0; k < 20; k++) begin
            btn_raw[2] = 1'b1;
            cyc("t7a");
        end
        repeat_en[2] = 1'b0;
        clr_cnt();
        for (int k = 0; k < 15; k++) cyc("t7b");
        chk("t7 pulses after drop", 32'(pcnt[2]), 32'd0);
        chk("t7 level after drop", 32'(btn_level[2]), 32'd1);
        idle(5);

        // Reset while channel 0 is repeating.
        repeat_en[0] = 1'b1;
        idle(4);
        for (int k = 0; k < 18; k++) begin
            btn_raw[0] = 1'b1;
            cyc("t6a");
        end
        reset = 1'b1;
        cyc("t6 rst");
        chk("t6 outputs after reset", 32'({btn_pulse, btn_level}), 32'd0);
        reset = 1'b0;
        clr_cnt();
        first = -1;
        for (int k = 0; k < 8; k++) begin
            cyc("t6b");
            if (btn_pulse[0] && first < 0) first = k + 1;
        end
        chk("t6 requalify edge", 32'(first), 32'd6);
        chk("t6 pulse count", 32'(pcnt[0]), 32'd1);
        idle(5);

        // Random segments: repeat_en only rises while released, may drop anytime.
        for (int seg = 0; seg < 25; seg++) begin
            idle(4);
            repeat_en = 4'($urandom_range(0, 15));
            for (int k = 0; k < 50; k++) begin
                for (int i = 0; i < NB; i++)
                    if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
                if ($urandom_range(0, 31) == 0)
                    repeat_en[$urandom_range(0, NB-1)] = 1'b0;
                reset = ($urandom_range(0, 79) == 0);
                cyc("rand");
            end
            reset = 1'b0;
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
